// File: rtl/parport_centronics_ctrl.sv
// Centronics transmit sequencer for the parallel port.
// Bytes from the ST-side write path are queued in a small FIFO and shifted out
// on pp_data with setup / /STROBE / hold timing, gated by the printer BUSY
// handshake and guarded by a per-byte timeout.
module parport_centronics_ctrl #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SETUP_CYC   = 32,
  parameter int STROBE_CYC  = 32,
  parameter int HOLD_CYC    = 32,
  parameter int TIMEOUT_CYC = 32000000
) (
  input  logic                        clk32,
  input  logic                        por,
  input  logic                        enable,
  input  logic                        flush,
  input  logic [7:0]                  wr_data,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic                        pp_busy,
  output logic [7:0]                  pp_data_out,
  output logic                        pp_data_oe,
  output logic                        pp_strobe_out,
  output logic                        pp_strobe_oe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        timeout,
  output logic                        idle
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 25;

  // Counter load values; the counter runs N-1 .. 0 so each phase lasts N cycles.
  // TIMEOUT_CYC must be at least 2 so the first WAIT_BUSY cycle is distinguishable.
  localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [AW:0]      DEPTH_L     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             strobe_q, strobe_d;
  logic             timeout_q, timeout_d;
  logic             en_q;
  logic             busy_meta_q, busy_s_q;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level;
  logic             empty, full;
  logic             push, pop;

  // Pointers carry one extra wrap bit, so their difference is the fill level.
  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == DEPTH_L);
  assign push     = wr_valid & ~full & ~flush;

  assign wr_ready      = ~full;
  assign fifo_level    = level;
  assign pp_data_out   = data_q;
  assign pp_strobe_out = strobe_q;
  assign pp_data_oe    = en_q;
  assign pp_strobe_oe  = en_q;
  assign timeout       = timeout_q;
  assign idle          = (state_q == ST_IDLE) & empty;

  // Two-flop synchronizer for the asynchronous BUSY pin, plus registered pin enable.
  always_ff @(posedge clk32) begin
    if (por) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      busy_meta_q <= pp_busy;
      busy_s_q    <= busy_meta_q;
      en_q        <= enable;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk32) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Sequencer next-state: flush beats everything, dropping enable aborts the
  // transfer but leaves the FIFO alone.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    timeout_d = timeout_q;
    pop       = 1'b0;

    if (flush) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            data_d  = mem_q[rd_ptr_q[AW-1:0]];
            state_d = ST_WAIT_BUSY;
            cnt_d   = TO_LOAD;
          end
        end
        ST_WAIT_BUSY: begin
          // busy_s lags the pin; skip the first cycle so the decision is made
          // on a sample taken after the new byte was presented.
          if (!busy_s_q && (cnt_q != TO_LOAD)) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
          end else if (cnt_q == '0) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt_q == '0) begin
            state_d = ST_STROBE;
            cnt_d   = STROBE_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_STROBE: begin
          if (cnt_q == '0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Strobe is registered from the next state so the pin never glitches.
    strobe_d = (state_d != ST_STROBE);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end
  end

  // Sequencer, output and pointer registers.
  always_ff @(posedge clk32) begin
    if (por) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= 8'h00;
      strobe_q  <= 1'b1;
      timeout_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      strobe_q  <= strobe_d;
      timeout_q <= timeout_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

endmodule
